// File: rtl/pipe_ctrl_if.sv
// Datapath-facing bundle of the pipe_ctrl sequencer.
// master = controller side, slave = datapath side.
interface pipe_ctrl_if #(
   parameter int PC_W = 32
);
   logic [23:0]     dec_inst;
   logic            dec_valid;
   logic            ex_br_taken;
   logic [PC_W-1:0] ex_br_target;
   logic [PC_W-1:0] pc;
   logic            fetch_en;
   logic            issue;
   logic            ex_nop;
   logic            stall;
   logic            halted;

   modport master (
      input  dec_inst, dec_valid, ex_br_taken, ex_br_target,
      output pc, fetch_en, issue, ex_nop, stall, halted
   );

   modport slave (
      output dec_inst, dec_valid, ex_br_taken, ex_br_target,
      input  pc, fetch_en, issue, ex_nop, stall, halted
   );
endinterface

// File: rtl/pipe_ctrl.sv
// 3-stage sequencer: PC, fetch enable, flush bubbles, RAW interlock, halt.
// Optional perf counters when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
   parameter int              PC_W      = 32,
   parameter int              FLUSH_CYC = 3,
   parameter logic [PC_W-1:0] START_PC  = '0
) (
   input  logic        ck,
   input  logic        rst_n,
   input  logic        run,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0] perf_cyc,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush,
`endif
   pipe_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

   localparam logic [2:0] FC = 3'(FLUSH_CYC);

   state_t          state, state_n;
   logic [2:0]      cnt, cnt_n;
   logic            sb_v, sb_v_n;
   logic [5:0]      sb_rd, sb_rd_n;
   logic [PC_W-1:0] pc_q, pc_n;
   logic            fe_q, fe_n;
   logic            iss_q, iss_n;
   logic            nop_q, nop_n;
   logic            st_q, st_n;
   logic            hlt_q, hlt_n;

   logic [1:0] ot;
   logic [3:0] op;
   logic [5:0] rd, rs, rt;
   logic       wr, use_rd, use_rs, use_rt;
   logic       hz, is_jmp, is_hlt, dec_run;

   assign {ot, op, rd, rs, rt} = bus.dec_inst;

   always_comb begin
      wr     = 1'b0;
      use_rd = 1'b0;
      use_rs = 1'b0;
      use_rt = 1'b0;
      unique case (ot)
         2'b00: begin
            wr = op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5,
                            4'd9, 4'd10, 4'd11};
            use_rs = 1'b1;
            use_rt = 1'b1;
            use_rd = op inside {4'd6, 4'd7};
         end
         2'b01: begin
            wr = op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5,
                            4'd9, 4'd10, 4'd11, 4'd13};
            use_rs = 1'b1;
            use_rd = op inside {4'd6, 4'd7, 4'd12};
         end
         default: ;
      endcase
   end

   assign hz = bus.dec_valid & sb_v &
               ((use_rs & (rs == sb_rd)) |
                (use_rt & (rt == sb_rd)) |
                (use_rd & (rd == sb_rd)));
   assign is_jmp = bus.dec_valid & (ot == 2'b10);
   assign is_hlt = bus.dec_valid & (ot == 2'b11) & (op == 4'hf);
   // the last flush cycle already decides like RUN
   assign dec_run = (state == RUN) |
                    ((state == FLUSH) & (cnt == 3'd1));

   always_ff @(posedge ck) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (run) state_n = RUN;
         RUN, FLUSH: begin
            if (dec_run & is_hlt)
               state_n = HALT;
            else if (bus.ex_br_taken | (dec_run & is_jmp))
               state_n = FLUSH;
            else if (dec_run)
               state_n = RUN;
         end
         HALT: state_n = HALT;
      endcase
   end

   always_comb begin
      pc_n    = pc_q;
      cnt_n   = cnt;
      fe_n    = 1'b0;
      iss_n   = 1'b0;
      nop_n   = 1'b1;
      st_n    = 1'b0;
      hlt_n   = hlt_q;
      sb_v_n  = 1'b0;
      sb_rd_n = sb_rd;
      if (state == IDLE) begin
         fe_n = run;
      end else if (state == HALT) begin
         fe_n = 1'b0;
      end else if (dec_run & is_hlt) begin
         hlt_n = 1'b1;
         cnt_n = 3'd0;
      end else if (bus.ex_br_taken) begin
         pc_n  = bus.ex_br_target;
         cnt_n = FC;
         fe_n  = 1'b1;
      end else if (dec_run & is_jmp) begin
         pc_n  = PC_W'(rt);
         cnt_n = FC;
         fe_n  = 1'b1;
      end else if (dec_run & hz) begin
         st_n  = 1'b1;
         cnt_n = 3'd0;
      end else if (dec_run) begin
         pc_n    = pc_q + PC_W'(1);
         cnt_n   = 3'd0;
         fe_n    = 1'b1;
         iss_n   = bus.dec_valid;
         nop_n   = ~bus.dec_valid;
         sb_v_n  = bus.dec_valid & wr;
         sb_rd_n = rd;
      end else begin
         pc_n  = pc_q + PC_W'(1);
         cnt_n = cnt - 3'd1;
         fe_n  = 1'b1;
      end
   end

   always_ff @(posedge ck) begin
      if (!rst_n) begin
         pc_q  <= START_PC;
         cnt   <= 3'd0;
         sb_v  <= 1'b0;
         sb_rd <= 6'd0;
         fe_q  <= 1'b0;
         iss_q <= 1'b0;
         nop_q <= 1'b1;
         st_q  <= 1'b0;
         hlt_q <= 1'b0;
      end else begin
         pc_q  <= pc_n;
         cnt   <= cnt_n;
         sb_v  <= sb_v_n;
         sb_rd <= sb_rd_n;
         fe_q  <= fe_n;
         iss_q <= iss_n;
         nop_q <= nop_n;
         st_q  <= st_n;
         hlt_q <= hlt_n;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.fetch_en = fe_q;
   assign bus.issue    = iss_q;
   assign bus.ex_nop   = nop_q;
   assign bus.stall    = st_q;
   assign bus.halted   = hlt_q;

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge ck) begin
      if (!rst_n) begin
         perf_cyc   <= '0;
         perf_stall <= '0;
         perf_flush <= '0;
      end else begin
         if (((state == RUN) | (state == FLUSH)) & (perf_cyc != '1))
            perf_cyc <= perf_cyc + 32'd1;
         if (st_q & (perf_stall != '1))
            perf_stall <= perf_stall + 32'd1;
         if ((state == FLUSH) & (perf_flush != '1))
            perf_flush <= perf_flush + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, halt hold,
// then random stimulus against a behavioural model.
module tb_pipe_ctrl;
   localparam int PC_W = 32;
   localparam int FC   = 3;
   localparam int NV   = 25;

   logic ck = 1'b0;
   logic rst_n = 1'b0;
   logic run = 1'b0;
   int   checks = 0;
   int   failures = 0;

   pipe_ctrl_if #(.PC_W(PC_W)) bus ();

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_cyc, perf_stall, perf_flush;
`endif

   pipe_ctrl #(.PC_W(PC_W), .FLUSH_CYC(FC), .START_PC('0)) dut (
      .ck(ck),
      .rst_n(rst_n),
      .run(run),
`ifdef PIPE_CTRL_PERF_EN
      .perf_cyc(perf_cyc),
      .perf_stall(perf_stall),
      .perf_flush(perf_flush),
`endif
      .bus(bus.master)
   );

   always #5 ck = ~ck;

   typedef struct {
      bit          r, ru, dv;
      logic [23:0] inst;
      bit          br;
      logic [31:0] tgt;
      logic [31:0] pc;
      bit          fe, iss, nop, st, hlt;
   } vec_t;

   vec_t tv[NV];

   bit          m_act, m_hlt, m_sbv;
   int          m_fl, m_sbrd;
   logic [31:0] e_pc;
   bit          e_fe, e_iss, e_nop, e_st, e_hlt;

   function automatic logic [23:0] mk(int ot, int op, int rd, int rs, int rt);
      return {2'(ot), 4'(op), 6'(rd), 6'(rs), 6'(rt)};
   endfunction

   function automatic vec_t mkv(bit r, bit ru, bit dv, logic [23:0] in,
                                bit br, logic [31:0] tg, logic [31:0] pc,
                                bit fe, bit iss, bit nop, bit st, bit hlt);
      vec_t x;
      x.r = r; x.ru = ru; x.dv = dv; x.inst = in; x.br = br; x.tgt = tg;
      x.pc = pc; x.fe = fe; x.iss = iss; x.nop = nop; x.st = st; x.hlt = hlt;
      return x;
   endfunction

   task automatic drive(bit r, bit ru, bit dv, logic [23:0] in,
                        bit br, logic [31:0] tg);
      rst_n            = r;
      run              = ru;
      bus.dec_valid    = dv;
      bus.dec_inst     = in;
      bus.ex_br_taken  = br;
      bus.ex_br_target = tg;
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [31:0] pc, bit fe, bit iss,
                          bit nop, bit st, bit hlt);
      chk({tag, ".pc"}, bus.pc, pc);
      chk({tag, ".fetch_en"}, 32'(bus.fetch_en), 32'(fe));
      chk({tag, ".issue"}, 32'(bus.issue), 32'(iss));
      chk({tag, ".ex_nop"}, 32'(bus.ex_nop), 32'(nop));
      chk({tag, ".stall"}, 32'(bus.stall), 32'(st));
      chk({tag, ".halted"}, 32'(bus.halted), 32'(hlt));
   endtask

   function automatic bit m_reads(logic [23:0] i, int r);
      int ot = int'(i[23:22]);
      int op = int'(i[21:18]);
      int rd = int'(i[17:12]);
      int rs = int'(i[11:6]);
      int rt = int'(i[5:0]);
      if (ot == 0) return rs == r || rt == r || (op inside {6, 7} && rd == r);
      if (ot == 1) return rs == r || (op inside {6, 7, 12} && rd == r);
      return 1'b0;
   endfunction

   function automatic bit m_writes(logic [23:0] i);
      int ot = int'(i[23:22]);
      int op = int'(i[21:18]);
      if (ot == 0) return op inside {0, 1, 2, 4, 5, 9, 10, 11};
      if (ot == 1) return op inside {0, 1, 2, 4, 5, 9, 10, 11, 13};
      return 1'b0;
   endfunction

   // expected outputs after the coming edge, from the inputs now applied
   task automatic model_step();
      bit          br = bus.ex_br_taken;
      bit          dv = bus.dec_valid;
      logic [23:0] in = bus.dec_inst;
      bit          old_sbv = m_sbv;
      e_st  = 1'b0;
      e_iss = 1'b0;
      e_nop = 1'b1;
      m_sbv = 1'b0;
      if (!rst_n) begin
         m_act = 1'b0; m_hlt = 1'b0; m_fl = 0;
         e_pc = '0; e_fe = 1'b0;
      end else if (m_hlt || !m_act) begin
         e_fe = 1'b0;
         if (!m_hlt && run) begin m_act = 1'b1; e_fe = 1'b1; end
      end else if (m_fl > 1) begin
         e_fe = 1'b1;
         if (br) begin e_pc = bus.ex_br_target; m_fl = FC; end
         else begin e_pc = e_pc + 1; m_fl = m_fl - 1; end
      end else begin
         m_fl = 0;
         e_fe = 1'b1;
         if (dv && in[23:22] == 2'd3 && in[21:18] == 4'hf) begin
            m_hlt = 1'b1; e_fe = 1'b0;
         end else if (br) begin
            e_pc = bus.ex_br_target; m_fl = FC;
         end else if (dv && in[23:22] == 2'd2) begin
            e_pc = 32'(in[5:0]); m_fl = FC;
         end else if (dv && old_sbv && m_reads(in, m_sbrd)) begin
            e_st = 1'b1; e_fe = 1'b0;
         end else begin
            e_pc = e_pc + 1;
            if (dv) begin
               e_iss = 1'b1; e_nop = 1'b0;
               m_sbv = m_writes(in); m_sbrd = int'(in[17:12]);
            end
         end
      end
      e_hlt = m_hlt;
   endtask

   initial begin
      logic [23:0] addi1, addi2, addi3, addi4, addi5, add21, halt;
      logic [23:0] j6, j9, j12;
      addi1 = mk(1, 0, 1, 0, 0);
      addi2 = mk(1, 0, 2, 0, 0);
      addi3 = mk(1, 0, 3, 0, 0);
      addi4 = mk(1, 0, 4, 0, 0);
      addi5 = mk(1, 0, 5, 0, 0);
      add21 = mk(0, 0, 2, 1, 1);
      halt  = mk(3, 15, 0, 0, 0);
      j6    = mk(2, 0, 0, 0, 6);
      j9    = mk(2, 0, 0, 0, 9);
      j12   = mk(2, 0, 0, 0, 12);

      tv[0]  = mkv(0, 0, 0, '0,    0, '0, 0, 0, 0, 1, 0, 0);
      tv[1]  = mkv(1, 1, 0, '0,    0, '0, 0, 1, 0, 1, 0, 0);
      tv[2]  = mkv(1, 1, 1, addi1, 0, '0, 1, 1, 1, 0, 0, 0);
      tv[3]  = mkv(1, 1, 1, addi2, 0, '0, 2, 1, 1, 0, 0, 0);
      tv[4]  = mkv(1, 1, 1, addi3, 0, '0, 3, 1, 1, 0, 0, 0);
      tv[5]  = mkv(1, 1, 1, addi1, 0, '0, 4, 1, 1, 0, 0, 0);
      tv[6]  = mkv(1, 1, 1, add21, 0, '0, 4, 0, 0, 1, 1, 0);
      tv[7]  = mkv(1, 1, 1, add21, 0, '0, 5, 1, 1, 0, 0, 0);
      tv[8]  = mkv(1, 1, 1, j6,    0, '0, 6, 1, 0, 1, 0, 0);
      tv[9]  = mkv(1, 1, 1, addi5, 0, '0, 7, 1, 0, 1, 0, 0);
      tv[10] = mkv(1, 1, 1, addi5, 1, 32'h20, 32'h20, 1, 0, 1, 0, 0);
      tv[11] = mkv(1, 1, 1, j9,    0, '0, 32'h21, 1, 0, 1, 0, 0);
      tv[12] = mkv(1, 1, 1, addi4, 0, '0, 32'h22, 1, 0, 1, 0, 0);
      tv[13] = mkv(1, 1, 1, addi4, 0, '0, 32'h23, 1, 1, 0, 0, 0);
      tv[14] = mkv(1, 1, 1, j12,   0, '0, 12, 1, 0, 1, 0, 0);
      tv[15] = mkv(0, 1, 1, addi1, 0, '0, 0, 0, 0, 1, 0, 0);
      tv[16] = mkv(1, 0, 1, addi1, 1, 32'h40, 0, 0, 0, 1, 0, 0);
      tv[17] = mkv(1, 1, 0, '0,    0, '0, 0, 1, 0, 1, 0, 0);
      tv[18] = mkv(1, 1, 1, addi1, 0, '0, 1, 1, 1, 0, 0, 0);
      tv[19] = mkv(1, 1, 1, mk(1, 0, 2, 1, 0), 1, 32'hffff_ffff,
                   32'hffff_ffff, 1, 0, 1, 0, 0);
      tv[20] = mkv(1, 1, 0, '0,    0, '0, 0, 1, 0, 1, 0, 0);
      tv[21] = mkv(1, 1, 0, '0,    0, '0, 1, 1, 0, 1, 0, 0);
      tv[22] = mkv(1, 1, 1, addi1, 0, '0, 2, 1, 1, 0, 0, 0);
      tv[23] = mkv(1, 1, 1, halt,  1, 32'h50, 2, 0, 0, 1, 0, 1);
      tv[24] = mkv(1, 1, 1, addi2, 1, 32'h60, 2, 0, 0, 1, 0, 1);

      for (int k = 0; k < NV; k++) begin
         drive(tv[k].r, tv[k].ru, tv[k].dv, tv[k].inst, tv[k].br, tv[k].tgt);
         @(posedge ck);
         #1;
         chk_all($sformatf("v%0d", k), tv[k].pc, tv[k].fe, tv[k].iss,
                 tv[k].nop, tv[k].st, tv[k].hlt);
      end

      // halt holds pc under continued activity for 50 cycles
      for (int k = 0; k < 50; k++) begin
         drive(1, 1, 1, addi3, k[0], 32'(k) + 32'h100);
         @(posedge ck);
         #1;
         chk("hold.pc", bus.pc, 32'd2);
         chk("hold.halted", 32'(bus.halted), 32'd1);
         chk("hold.fetch_en", 32'(bus.fetch_en), 32'd0);
      end
      drive(0, 1, 0, '0, 0, '0);
      @(posedge ck);
      #1;
      chk_all("halt_rst", 32'd0, 0, 0, 1, 0, 0);

      for (int k = 0; k < 2000; k++) begin
         bit          r, ru, dv, br;
         int          ot, op;
         logic [23:0] in;
         r  = (k == 0) ? 1'b0 : ($urandom % 50) != 0;
         ru = ($urandom % 8) != 0;
         dv = ($urandom % 4) != 0;
         ot = int'($urandom % 4);
         op = int'($urandom % 16);
         if (ot == 3 && op == 15 && ($urandom % 10) != 0) op = 14;
         in = mk(ot, op, int'($urandom % 4), int'($urandom % 4),
                 int'($urandom % 64));
         br = ($urandom % 10) == 0;
         drive(r, ru, dv, in, br, $urandom);
         model_step();
         @(posedge ck);
         #1;
         chk_all($sformatf("rnd%0d", k), e_pc, e_fe, e_iss, e_nop, e_st, e_hlt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
